// File: rtl/imm_encoder_if.sv
// Request/response stream bundle between the instruction patcher and the encoder.
// The master side issues field requests and consumes encoded words.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  in_ready,
      input  out_valid, out_inst, out_err,
      output out_ready
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output in_ready,
      output out_valid, out_inst, out_err,
      input  out_ready
   );
endinterface

// File: rtl/imm_encoder.sv
// Packs RV32I fields plus a byte-offset immediate into an instruction word, flags
// out-of-range/misaligned immediates, and streams results through an output reg + skid.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   imm_encoder_if.slave     bus,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic               r_out_valid;
   logic [31:0]        r_out_inst;
   logic               r_out_err;
   logic               r_skid_valid;
   logic [31:0]        r_skid_inst;
   logic               r_skid_err;
   logic [CNT_W-1:0]   r_err_cnt;

   logic               w_accept;
   logic [31:0]        w_inst;
   logic               w_err;
   logic signed [31:0] w_imm_s;
   logic               w_range12;
   logic               w_range13;
   logic               w_range21;
   logic [31:0]        w_imm;

   assign w_imm     = bus.in_imm;
   assign w_imm_s   = $signed(bus.in_imm);
   assign w_range12 = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
   assign w_range13 = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094);
   assign w_range21 = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574);

   // Unknown opcodes still get I-type packing so the word is deterministic.
   always_comb begin
      w_inst = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      w_err  = 1'b1;
      case (bus.in_opcode)
         OP_R: begin
            w_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            w_err  = 1'b0;
         end
         OP_LOAD, OP_IMM, OP_JALR: begin
            w_err = !w_range12;
         end
         OP_STORE: begin
            w_inst = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
            w_err  = !w_range12;
         end
         OP_BRANCH: begin
            w_inst = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      w_imm[4:1], w_imm[11], bus.in_opcode};
            w_err  = !w_range13 || w_imm[0];
         end
         OP_AUIPC, OP_LUI: begin
            w_inst = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            w_err  = (w_imm[11:0] != 12'd0);
         end
         OP_JAL: begin
            w_inst = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
            w_err  = !w_range21 || w_imm[0];
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = !r_skid_valid;
   assign w_accept      = bus.in_valid && !r_skid_valid;
   assign bus.out_valid = r_out_valid;
   assign bus.out_inst  = r_out_inst;
   assign bus.out_err   = r_out_err;
   assign err_cnt       = r_err_cnt;

   // A full skid blocks input, so draining and accepting never happen together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_inst   <= 32'd0;
         r_out_err    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_inst  <= 32'd0;
         r_skid_err   <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         if (r_skid_valid) begin
            if (bus.out_ready) begin
               r_out_inst   <= r_skid_inst;
               r_out_err    <= r_skid_err;
               r_skid_valid <= 1'b0;
            end
         end else if (w_accept) begin
            if (!r_out_valid || bus.out_ready) begin
               r_out_inst  <= w_inst;
               r_out_err   <= w_err;
               r_out_valid <= 1'b1;
            end else begin
               r_skid_inst  <= w_inst;
               r_skid_err   <= w_err;
               r_skid_valid <= 1'b1;
            end
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
      end
   end

endmodule
